// File: rtl/seg7_scan_if.sv
// Display driver bus: datapath-side inputs and board-side
// segment/anode outputs of the multiplexed hex display.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 3
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    scan_tick;

  modport master (
    output value, dp_in, digit_en, lz_blank, load,
    input  seg, dp_n, an, digit_idx, scan_tick
  );

  modport slave (
    input  value, dp_in, digit_en, lz_blank, load,
    output seg, dp_n, an, digit_idx, scan_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex display driver with shadowed value,
// per-digit enable, decimal points and leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = 3
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ?
                         $clog2(REFRESH_DIV) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick_q, tick_d;
  logic [DW-1:0]         val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [IDX_W-1:0]      didx_q, didx_d;

  logic [DW-1:0]         shifted;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic                  sup;
  logic                  dp_lit;
  logic                  en;
  logic [NUM_DIGITS-1:0] onehot_n;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    tick_d = 1'b0;
    val_d  = val_q;
    dp_d   = dp_q;
    if (bus.load) begin
      val_d = bus.value;
      dp_d  = bus.dp_in;
    end
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Presentation is built from the registered index and shadow.
  always_comb begin
    shifted  = val_q >> {idx_q, 2'b00};
    nib      = shifted[3:0];
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) >= idx_q && val_q[4*j +: 4] != 4'h0)
        upper_nz = 1'b1;
    end
    sup      = bus.lz_blank && (idx_q != '0) && !upper_nz;
    dp_lit   = dp_q[idx_q];
    en       = bus.digit_en[idx_q];
    onehot_n = ~(NUM_DIGITS'(1) << idx_q);
    seg_d    = 7'b1111111;
    dpn_d    = 1'b1;
    an_d     = '1;
    didx_d   = idx_q;
    if (!en) begin
      an_d = '1;
    end else if (sup) begin
      dpn_d = ~dp_lit;
      if (dp_lit) an_d = onehot_n;
    end else begin
      an_d  = onehot_n;
      seg_d = glyph(nib);
      dpn_d = ~dp_lit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      val_q  <= '0;
      dp_q   <= '0;
      seg_q  <= 7'b1111111;
      dpn_q  <= 1'b1;
      an_q   <= '1;
      didx_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      val_q  <= val_d;
      dp_q   <= dp_d;
      seg_q  <= seg_d;
      dpn_q  <= dpn_d;
      an_q   <= an_d;
      didx_q <= didx_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp_n      = dpn_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = didx_q;
  assign bus.scan_tick = tick_q;
endmodule
